// File: rtl/matmul_pkg.sv
// Shared sizing, element type and FSM encoding for the matmul block.
package matmul_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int M          = 32;
    localparam int IDX_W      = $clog2(M);
    localparam int ELEM_W     = 2 * DATA_WIDTH + IDX_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

    typedef logic signed [ELEM_W-1:0] mat_elem;

    typedef enum logic {
        COMPUTE = 1'b0,
        DONE    = 1'b1
    } state_e;
endpackage

// File: rtl/matmul_dot.sv
// M-wide dot product: parallel multipliers feeding a balanced adder tree.
// MATMUL_PIPE_EN inserts a register stage between the products and the tree.
module matmul_dot
    import matmul_pkg::*;
(
`ifdef MATMUL_PIPE_EN
    input  logic    clk_i,
`endif
    input  mat_elem a_i [M-1:0],
    input  mat_elem b_i [M-1:0],
    output mat_elem sum_o
);
    mat_elem prod_d  [M-1:0];
    mat_elem tree_in [M-1:0];

    // Products keep only the low ELEM_W bits; the sum wraps at the same width.
    always_comb begin
        for (int k = 0; k < M; k++) begin
            prod_d[k] = a_i[k] * b_i[k];
        end
    end

`ifdef MATMUL_PIPE_EN
    mat_elem prod_q [M-1:0];

    always_ff @(posedge clk_i) begin
        prod_q <= prod_d;
    end

    assign tree_in = prod_q;
`else
    assign tree_in = prod_d;
`endif

    // Pairwise reduction, halving the live width each level.
    always_comb begin
        mat_elem acc [M-1:0];
        acc = tree_in;
        for (int lvl = 0; lvl < IDX_W; lvl++) begin
            for (int k = 0; k < (M >> (lvl + 1)); k++) begin
                acc[k] = acc[2*k] + acc[2*k+1];
            end
        end
        sum_o = acc[0];
    end
endmodule

// File: rtl/matmul.sv
// Row-major matrix multiplier: one outmat element per clock, then holds.
// Build option MATMUL_PIPE_EN delays each write by one edge.
module matmul
    import matmul_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  mat_elem mat1   [M-1:0][M-1:0],
    input  mat_elem mat2   [M-1:0][M-1:0],
    output mat_elem outmat [M-1:0][M-1:0]
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic [IDX_W-1:0] wr_i, wr_j;
    logic             wr_en, last_wr;
    mat_elem          row_vec  [M-1:0];
    mat_elem          col_vec  [M-1:0];
    mat_elem          dot_sum;
    mat_elem          outmat_q [M-1:0][M-1:0];

    always_comb begin
        for (int k = 0; k < M; k++) begin
            row_vec[k] = mat1[i_q][k];
            col_vec[k] = mat2[k][j_q];
        end
    end

    matmul_dot u_dot (
`ifdef MATMUL_PIPE_EN
        .clk_i (clk),
`endif
        .a_i   (row_vec),
        .b_i   (col_vec),
        .sum_o (dot_sum)
    );

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (state_q == COMPUTE) begin
            j_d = j_q + 1'b1;
            if (j_q == LAST_IDX) begin
                i_d = i_q + 1'b1;
            end
        end
    end

`ifdef MATMUL_PIPE_EN
    logic             wr_vld_q;
    logic [IDX_W-1:0] wi_q, wj_q;

    // Write-side index/valid follow the product register by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_vld_q <= 1'b0;
        end else begin
            wr_vld_q <= (state_q == COMPUTE);
        end
        wi_q <= i_q;
        wj_q <= j_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COMPUTE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == COMPUTE) && last_wr) begin
            state_d = DONE;
        end
    end

    always_comb begin
`ifdef MATMUL_PIPE_EN
        wr_en = wr_vld_q && (state_q == COMPUTE);
        wr_i  = wi_q;
        wr_j  = wj_q;
`else
        wr_en = (state_q == COMPUTE);
        wr_i  = i_q;
        wr_j  = j_q;
`endif
        last_wr = wr_en && (wr_i == LAST_IDX) && (wr_j == LAST_IDX);
    end

    // Reset clears the whole result so unwritten elements read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < M; c++) begin
                    outmat_q[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            outmat_q[wr_i][wr_j] <= dot_sum;
        end
    end

    assign outmat = outmat_q;
endmodule

// File: tb/tb_matmul.sv
// Self-checking bench for matmul against a plain software matrix-multiply model.
module tb_matmul;
    import matmul_pkg::*;

`ifdef MATMUL_PIPE_EN
    localparam int EX = 1;
`else
    localparam int EX = 0;
`endif
    localparam int NN = M * M;

    logic    clk   = 1'b0;
    logic    reset = 1'b1;
    mat_elem mat1   [M-1:0][M-1:0];
    mat_elem mat2   [M-1:0][M-1:0];
    mat_elem outmat [M-1:0][M-1:0];
    mat_elem expm   [M-1:0][M-1:0];
    int      checks = 0;
    int      errors = 0;

    always #5 clk = ~clk;

    matmul dut (
        .clk    (clk),
        .reset  (reset),
        .mat1   (mat1),
        .mat2   (mat2),
        .outmat (outmat)
    );

    function automatic mat_elem rnd03();
        return mat_elem'($urandom_range(3));
    endfunction

    function automatic mat_elem rnd16();
        logic signed [15:0] s;
        s = 16'($urandom);
        return mat_elem'(s);
    endfunction

    function automatic mat_elem rnd37();
        return mat_elem'({$urandom, $urandom});
    endfunction

    task automatic clear_ops();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat1[r][c] = '0;
                mat2[r][c] = '0;
            end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One reset edge, then release; the next edge is edge 1 of the run.
    task automatic start_run();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    // Software loop with ELEM_W-bit signed variables: truncating products, wrapping sum.
    task automatic compute_ref();
        mat_elem acc, p;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                acc = '0;
                for (int k = 0; k < M; k++) begin
                    p   = mat1[r][k] * mat2[k][c];
                    acc = acc + p;
                end
                expm[r][c] = acc;
            end
    endtask

    task automatic test_reset();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat1[r][c] = rnd16();
                mat2[r][c] = rnd16();
            end
        reset = 1'b1;
        step(2);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                checks++;
                if (outmat[r][c] !== '0) begin
                    errors++;
                    $display("FAIL reset[%0d][%0d]: got %0d expected 0", r, c, outmat[r][c]);
                end
            end
    endtask

    task automatic test_identity();
        clear_ops();
        for (int r = 0; r < M; r++) begin
            mat1[r][r] = mat_elem'(1);
            for (int c = 0; c < M; c++) mat2[r][c] = rnd03();
        end
        start_run();
        step(NN + 1);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                checks++;
                if (outmat[r][c] !== mat2[r][c]) begin
                    errors++;
                    $display("FAIL identity[%0d][%0d]: got %0d expected %0d",
                             r, c, outmat[r][c], mat2[r][c]);
                end
            end
    endtask

    task automatic test_random_latency();
        mat_elem want;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat1[r][c] = rnd03();
                mat2[r][c] = rnd03();
            end
        compute_ref();
        start_run();
        step(100);
        for (int idx = 0; idx < NN; idx++) begin
            want = (idx < 100 - EX) ? expm[idx / M][idx % M] : '0;
            checks++;
            if (outmat[idx / M][idx % M] !== want) begin
                errors++;
                $display("FAIL partial[%0d][%0d]: got %0d expected %0d",
                         idx / M, idx % M, outmat[idx / M][idx % M], want);
            end
        end
        step(1150);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                checks++;
                if (outmat[r][c] !== expm[r][c] || outmat[r][c] < 0 || outmat[r][c] > 288) begin
                    errors++;
                    $display("FAIL random[%0d][%0d]: got %0d expected %0d (range 0..288)",
                             r, c, outmat[r][c], expm[r][c]);
                end
            end
    endtask

    task automatic test_zero_pad();
        mat_elem want;
        clear_ops();
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 17; c++) mat1[r][c] = rnd16();
        for (int r = 0; r < 17; r++)
            for (int c = 0; c < 19; c++) mat2[r][c] = rnd16();
        compute_ref();
        start_run();
        step(NN + EX + 1);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                want = (r < 13 && c < 19) ? expm[r][c] : '0;
                checks++;
                if (outmat[r][c] !== want) begin
                    errors++;
                    $display("FAIL zeropad[%0d][%0d]: got %0d expected %0d",
                             r, c, outmat[r][c], want);
                end
            end
    endtask

    task automatic test_signed_wrap();
        mat_elem big;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat1[r][c] = '1;
                mat2[r][c] = '1;
            end
        start_run();
        step(NN + EX + 1);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                checks++;
                if (outmat[r][c] !== mat_elem'(M)) begin
                    errors++;
                    $display("FAIL minus1[%0d][%0d]: got %0d expected %0d", r, c, outmat[r][c], M);
                end
            end

        big = mat_elem'((64'd1 << 36) - 64'd1);
        clear_ops();
        mat1[0][0] = big;
        for (int k = 0; k < M; k++) mat2[k][k] = mat_elem'(1);
        start_run();
        step(NN + EX + 1);
        checks++;
        if (outmat[0][0] !== big) begin
            errors++;
            $display("FAIL bigval[0][0]: got %0d expected %0d", outmat[0][0], big);
        end
        checks++;
        if (outmat[0][1] !== '0) begin
            errors++;
            $display("FAIL bigval[0][1]: got %0d expected 0", outmat[0][1]);
        end

        // Full-width operands force product truncation and sum wrap everywhere.
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat1[r][c] = rnd37();
                mat2[r][c] = rnd37();
            end
        compute_ref();
        start_run();
        step(NN + EX + 1);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                checks++;
                if (outmat[r][c] !== expm[r][c]) begin
                    errors++;
                    $display("FAIL wrap[%0d][%0d]: got %0d expected %0d",
                             r, c, outmat[r][c], expm[r][c]);
                end
            end
    endtask

    task automatic test_reset_midrun();
        mat_elem want;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                mat1[r][c] = rnd16();
                mat2[r][c] = rnd16();
            end
        start_run();
        step(499);
        reset = 1'b1;
        step(1);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                checks++;
                if (outmat[r][c] !== '0) begin
                    errors++;
                    $display("FAIL midreset[%0d][%0d]: got %0d expected 0", r, c, outmat[r][c]);
                end
            end
        clear_ops();
        for (int k = 0; k < M; k++) begin
            mat1[k][k] = mat_elem'(2);
            mat2[k][k] = mat_elem'(3);
        end
        reset = 1'b0;
        step(NN + EX - 1);
        checks++;
        if (outmat[M-1][M-1] !== '0) begin
            errors++;
            $display("FAIL early_last: got %0d expected 0", outmat[M-1][M-1]);
        end
        checks++;
        if (outmat[M-2][M-2] !== mat_elem'(6)) begin
            errors++;
            $display("FAIL early_prev: got %0d expected 6", outmat[M-2][M-2]);
        end
        step(1);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++) begin
                want = (r == c) ? mat_elem'(6) : '0;
                checks++;
                if (outmat[r][c] !== want) begin
                    errors++;
                    $display("FAIL six_i[%0d][%0d]: got %0d expected %0d", r, c, outmat[r][c], want);
                end
            end
    endtask

    // Follows test_reset_midrun: the held result must stay 6*I.
    task automatic test_hold();
        mat_elem want;
        int      row;
        for (int n = 1; n <= 5000; n++) begin
            row = $urandom_range(M - 1);
            for (int c = 0; c < M; c++) begin
                mat1[row][c] = rnd37();
                mat2[c][row] = rnd37();
            end
            step(1);
            if (n % 1000 == 0) begin
                for (int r = 0; r < M; r++)
                    for (int c = 0; c < M; c++) begin
                        want = (r == c) ? mat_elem'(6) : '0;
                        checks++;
                        if (outmat[r][c] !== want) begin
                            errors++;
                            $display("FAIL hold@%0d[%0d][%0d]: got %0d expected %0d",
                                     n, r, c, outmat[r][c], want);
                        end
                    end
            end
        end
    endtask

    initial begin
        clear_ops();
        test_reset();
        test_identity();
        test_random_latency();
        test_zero_pad();
        test_signed_wrap();
        test_reset_midrun();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
